// File: rtl/mining_controller_if.sv
// Bundles the host-side control/status signals and the concatenator/hash-side
// signals of the mining controller into one port group.
interface mining_controller_if;
  logic        start;
  logic        abort;
  logic [95:0] data_entry_12;
  logic [7:0]  data_target;
  logic [23:0] hash_in;
  logic [95:0] entry_12;
  logic [31:0] nonce;
  logic        selector;
  logic [7:0]  target;
  logic        busy;
  logic        found;
  logic        exhausted;
  logic [31:0] golden_nonce;

  modport slave (
    input  start, abort, data_entry_12, data_target, hash_in,
    output entry_12, nonce, selector, target, busy, found, exhausted, golden_nonce
  );

  modport master (
    output start, abort, data_entry_12, data_target, hash_in,
    input  entry_12, nonce, selector, target, busy, found, exhausted, golden_nonce
  );
endinterface

// File: rtl/mining_controller.sv
// Nonce search sequencer: issues one block per nonce to the hash datapath,
// waits out the hash latency, and compares the result against the target.
module mining_controller #(
  parameter int unsigned HASH_LATENCY = 4,
  parameter logic [31:0] NONCE_START  = 32'h0000_0000,
  parameter logic [31:0] NONCE_LIMIT  = 32'hFFFF_FFFF
) (
  input  logic           clk,
  input  logic           reset,
  mining_controller_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, FOUND, EXHAUSTED} state_t;

  localparam logic [3:0] LAT = 4'(HASH_LATENCY);

  state_t     state;
  logic [3:0] lat_cnt;
  logic       hit;

  // Both upper hash bytes must be strictly below the target (unsigned).
  function automatic logic hash_hit(input logic [15:0] h, input logic [7:0] t);
    return (h[15:8] < t) && (h[7:0] < t);
  endfunction

  assign hit = hash_hit(bus.hash_in[23:8], bus.target);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      lat_cnt          <= '0;
      bus.entry_12     <= '0;
      bus.nonce        <= '0;
      bus.selector     <= 1'b0;
      bus.target       <= '0;
      bus.busy         <= 1'b0;
      bus.found        <= 1'b0;
      bus.exhausted    <= 1'b0;
      bus.golden_nonce <= '0;
    end else begin
      case (state)
        IDLE, FOUND, EXHAUSTED: begin
          if (bus.abort) begin
            bus.found     <= 1'b0;
            bus.exhausted <= 1'b0;
            state         <= IDLE;
          end else if (bus.start) begin
            bus.entry_12     <= bus.data_entry_12;
            bus.target       <= bus.data_target;
            bus.nonce        <= NONCE_START;
            bus.golden_nonce <= '0;
            bus.found        <= 1'b0;
            bus.exhausted    <= 1'b0;
            bus.selector     <= 1'b1;
            bus.busy         <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE, WAIT, CHECK: begin
          // Abort wins over anything the search would otherwise do this cycle.
          if (bus.abort) begin
            bus.selector <= 1'b0;
            bus.busy     <= 1'b0;
            lat_cnt      <= '0;
            state        <= IDLE;
          end else if (state == ISSUE) begin
            bus.selector <= 1'b0;
            lat_cnt      <= LAT;
            state        <= WAIT;
          end else if (state == WAIT) begin
            lat_cnt <= lat_cnt - 4'd1;
            if (lat_cnt == 4'd1) state <= CHECK;
          end else if (hit) begin
            bus.golden_nonce <= bus.nonce;
            bus.found        <= 1'b1;
            bus.busy         <= 1'b0;
            state            <= FOUND;
          end else if (bus.nonce == NONCE_LIMIT) begin
            // Limit test precedes the increment, so the nonce never wraps.
            bus.exhausted <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= EXHAUSTED;
          end else begin
            bus.nonce    <= bus.nonce + 32'd1;
            bus.selector <= 1'b1;
            state        <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mining_controller.sv
// Bench for mining_controller: behavioural hash model, selector scoreboard,
// table-driven match boundaries and hand-written multi-cycle sequences.
module tb_mining_controller;

  localparam int L = 4;

  logic clk;
  logic reset;

  mining_controller_if bus0();
  mining_controller_if bus1();

  mining_controller #(.HASH_LATENCY(L)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mining_controller #(.HASH_LATENCY(L), .NONCE_LIMIT(32'd2)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    logic [7:0]  tgt;
    logic [23:0] hash;
    logic        hit;
  } vec_t;

  typedef struct {
    logic        found;
    logic [31:0] nonce;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] prog0 [8];
  logic [23:0] prog1 [8];
  logic [31:0] sel_q [$];
  exp_t        exp_q [$];

  int          cnt0 = 0, cnt1 = 0;
  logic [23:0] pend0, pend1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] look0(input logic [31:0] n);
    return (n < 32'd8) ? prog0[n[2:0]] : 24'hFFFFFF;
  endfunction

  function automatic logic [23:0] look1(input logic [31:0] n);
    return (n < 32'd8) ? prog1[n[2:0]] : 24'hFFFFFF;
  endfunction

  // Hash model: result appears L cycles after the selector pulse; zero (which
  // would match any nonzero target) until then.
  always @(negedge clk) begin
    if (bus0.selector) begin
      cnt0 = L; pend0 = look0(bus0.nonce); bus0.hash_in = 24'h0;
    end else if (cnt0 > 0) begin
      cnt0--;
      if (cnt0 == 0) bus0.hash_in = pend0;
    end
    if (bus1.selector) begin
      cnt1 = L; pend1 = look1(bus1.nonce); bus1.hash_in = 24'h0;
    end else if (cnt1 > 0) begin
      cnt1--;
      if (cnt1 == 0) bus1.hash_in = pend1;
    end
  end

  // Scoreboard: every selector pulse on dut0 must carry the next expected nonce.
  always @(negedge clk) begin
    if (reset && bus0.selector) begin
      if (sel_q.size() == 0) chk("sel_unexpected", 1, 0);
      else chk("sel_nonce", bus0.nonce, sel_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start0(input logic [7:0] tgt, input logic [95:0] hdr);
    bus0.data_target   = tgt;
    bus0.data_entry_12 = hdr;
    bus0.start         = 1'b1;
    tick();
    bus0.start         = 1'b0;
  endtask

  task automatic abort0();
    bus0.abort = 1'b1;
    tick();
    bus0.abort = 1'b0;
  endtask

  task automatic clear_prog0();
    for (int k = 0; k < 8; k++) prog0[k] = 24'hFFFFFF;
  endtask

  vec_t        vecs [8];
  logic [95:0] hdr1, hdr2;
  exp_t        e;
  int          sel1;

  initial begin
    vecs[0] = '{8'h10, 24'h101000, 1'b0};
    vecs[1] = '{8'h10, 24'h0F1000, 1'b0};
    vecs[2] = '{8'h10, 24'h0F0F00, 1'b1};
    vecs[3] = '{8'h10, 24'h100F00, 1'b0};
    vecs[4] = '{8'h01, 24'h0000FF, 1'b1};
    vecs[5] = '{8'h00, 24'h000000, 1'b0};
    vecs[6] = '{8'hFF, 24'hFEFE00, 1'b1};
    vecs[7] = '{8'hFF, 24'hFFFE00, 1'b0};

    clear_prog0();
    for (int k = 0; k < 8; k++) prog1[k] = 24'hFFFFFF;
    bus0.start = 0; bus0.abort = 0; bus0.data_entry_12 = '0; bus0.data_target = '0; bus0.hash_in = '0;
    bus1.start = 0; bus1.abort = 0; bus1.data_entry_12 = '0; bus1.data_target = '0; bus1.hash_in = '0;
    reset = 1'b1;
    #3 reset = 1'b0;
    #20;
    chk("rst_busy", bus0.busy, 0);
    chk("rst_found", bus0.found, 0);
    chk("rst_exh", bus0.exhausted, 0);
    chk("rst_sel", bus0.selector, 0);
    chk("rst_nonce", bus0.nonce, 0);
    chk("rst_golden", bus0.golden_nonce, 0);
    chk("rst_entry", bus0.entry_12, 0);
    chk("rst_target", bus0.target, 0);
    chk("rst_exh1", bus1.exhausted, 0);
    #2 reset = 1'b1;
    tick();

    // Match boundaries on nonce 0: found after CHECK, else moves on to nonce 1.
    for (int v = 0; v < 8; v++) begin
      clear_prog0();
      prog0[0] = vecs[v].hash;
      sel_q.push_back(32'd0);
      if (!vecs[v].hit) sel_q.push_back(32'd1);
      exp_q.push_back('{vecs[v].hit, vecs[v].hit ? 32'd0 : 32'd1});
      hdr1 = {$urandom, $urandom, $urandom};
      start0(vecs[v].tgt, hdr1);
      chk("vec_entry", bus0.entry_12, hdr1);
      chk("vec_target", bus0.target, vecs[v].tgt);
      repeat (6) tick();
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_found", v), bus0.found, e.found);
      chk($sformatf("vec%0d_nonce", v), bus0.nonce, e.nonce);
      chk($sformatf("vec%0d_busy", v), bus0.busy, !e.found);
      abort0();
      chk("vec_abort_found", bus0.found, 0);
    end

    // Full search: match on nonce 3, stray start while busy is ignored.
    clear_prog0();
    prog0[3] = 24'h0F0F00;
    for (int k = 0; k < 4; k++) sel_q.push_back(32'(k));
    hdr1 = {32'hA5A5_0001, 32'h1234_5678, 32'hDEAD_BEEF};
    start0(8'h10, hdr1);
    for (int i = 0; i <= 24; i++) begin
      chk($sformatf("srch_sel_%0d", i), bus0.selector, (i % 6 == 0) && (i <= 18));
      if (i == 23) chk("srch_found_early", bus0.found, 0);
      if (i == 9) begin
        bus0.data_entry_12 = ~hdr1;
        bus0.data_target   = 8'hEE;
        bus0.start         = 1'b1;
      end
      if (i == 10) bus0.start = 1'b0;
      if (i < 24) tick();
    end
    chk("srch_found", bus0.found, 1);
    chk("srch_golden", bus0.golden_nonce, 3);
    chk("srch_busy", bus0.busy, 0);
    chk("srch_nonce", bus0.nonce, 3);
    chk("srch_entry_held", bus0.entry_12, hdr1);
    chk("srch_target_held", bus0.target, 8'h10);

    // Restart from FOUND with a new header.
    hdr2 = {32'h0BAD_F00D, 32'h5555_AAAA, 32'h0000_0042};
    sel_q.push_back(32'd0);
    start0(8'h20, hdr2);
    chk("re_nonce", bus0.nonce, 0);
    chk("re_golden", bus0.golden_nonce, 0);
    chk("re_found", bus0.found, 0);
    chk("re_busy", bus0.busy, 1);
    chk("re_entry", bus0.entry_12, hdr2);
    chk("re_target", bus0.target, 8'h20);
    abort0();
    chk("re_abort_busy", bus0.busy, 0);

    // Abort during WAIT of nonce 1 with a simultaneous start.
    clear_prog0();
    sel_q.push_back(32'd0);
    sel_q.push_back(32'd1);
    start0(8'h10, hdr1);
    repeat (8) tick();
    bus0.abort = 1'b1;
    bus0.start = 1'b1;
    tick();
    bus0.abort = 1'b0;
    bus0.start = 1'b0;
    chk("ab_busy", bus0.busy, 0);
    chk("ab_sel", bus0.selector, 0);
    chk("ab_nonce", bus0.nonce, 1);
    chk("ab_found", bus0.found, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("ab_idle_busy", bus0.busy, 0);
    end

    // Abort in CHECK beats a matching hash.
    prog0[0] = 24'h0F0F00;
    sel_q.push_back(32'd0);
    start0(8'h10, hdr1);
    repeat (5) tick();
    abort0();
    chk("abm_found", bus0.found, 0);
    chk("abm_golden", bus0.golden_nonce, 0);
    chk("abm_busy", bus0.busy, 0);

    // Asynchronous reset mid-WAIT, no resume afterwards.
    clear_prog0();
    sel_q.push_back(32'd0);
    start0(8'h10, hdr1);
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    chk("ar_busy", bus0.busy, 0);
    chk("ar_sel", bus0.selector, 0);
    chk("ar_entry", bus0.entry_12, 0);
    chk("ar_target", bus0.target, 0);
    chk("ar_found", bus0.found, 0);
    #2 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("ar_idle_busy", bus0.busy, 0);
    end

    // Exhaustion on the NONCE_LIMIT=2 instance.
    prog1[1] = 24'h0F1000;
    sel1 = 0;
    bus1.data_target   = 8'h10;
    bus1.data_entry_12 = hdr2;
    bus1.start         = 1'b1;
    tick();
    bus1.start         = 1'b0;
    for (int i = 0; i <= 24; i++) begin
      if (bus1.selector) sel1++;
      if (i == 17) chk("ex_early", bus1.exhausted, 0);
      if (i == 18) begin
        chk("ex_exhausted", bus1.exhausted, 1);
        chk("ex_nonce", bus1.nonce, 2);
        chk("ex_found", bus1.found, 0);
        chk("ex_busy", bus1.busy, 0);
      end
      tick();
    end
    chk("ex_pulses", sel1, 3);
    chk("ex_held", bus1.exhausted, 1);

    chk("sel_q_drained", sel_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mining_controller.md
MINING_CONTROLLER -- requirements
Module: mining_controller

Interface
REQ-001 Parameter HASH_LATENCY, default 4, cycles from selector pulse to valid hash_in; legal range 1..15.
REQ-002 Parameter NONCE_START, default 32'h0000_0000, first nonce issued after start.
REQ-003 Parameter NONCE_LIMIT, default 32'hFFFF_FFFF, last nonce tried before giving up.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a new search; sampled only in IDLE, FOUND, EXHAUSTED.
REQ-007 abort  input  1  cancel the current search.
REQ-008 data_entry_12  input  96  block header words, latched on accepted start.
REQ-009 data_target  input  8  difficulty target, latched on accepted start.
REQ-010 hash_in  input  24  hash result from the hash datapath.
REQ-011 entry_12  output  96  latched header driven to the concatenator.
REQ-012 nonce  output  32  current nonce driven to the concatenator.
REQ-013 selector  output  1  one-cycle strobe telling the concatenator to build a block.
REQ-014 target  output  8  latched target driven to the hash.
REQ-015 busy  output  1  high while a search is in progress.
REQ-016 found  output  1  high while in FOUND.
REQ-017 exhausted  output  1  high while in EXHAUSTED.
REQ-018 golden_nonce  output  32  nonce that satisfied the target.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, CHECK, FOUND, EXHAUSTED.
REQ-020 Accepted start at edge k: latch data_entry_12/data_target, nonce <= NONCE_START, golden_nonce <= 0, found/exhausted clear, go to ISSUE.
REQ-021 ISSUE: selector=1 for exactly that one cycle, then go to WAIT with the latency counter loaded to HASH_LATENCY.
REQ-022 WAIT: decrement counter each cycle; after HASH_LATENCY cycles go to CHECK; selector=0 throughout.
REQ-023 CHECK: match when hash_in[23:16] < target AND hash_in[15:8] < target (unsigned, strict).
REQ-024 CHECK with match: golden_nonce <= nonce, go to FOUND.
REQ-025 CHECK without match and nonce == NONCE_LIMIT: go to EXHAUSTED, nonce held.
REQ-026 CHECK without match otherwise: nonce <= nonce + 1, go to ISSUE; per-nonce period is HASH_LATENCY + 2 cycles.
REQ-027 Nonce increment SHALL be 32-bit modular; NONCE_LIMIT check precedes increment, so no wrap occurs when NONCE_LIMIT = 32'hFFFF_FFFF.
REQ-028 busy SHALL be 1 in ISSUE, WAIT, CHECK and 0 elsewhere.
REQ-029 start while busy SHALL be ignored.
REQ-030 abort in ISSUE/WAIT/CHECK: next state IDLE, busy=0, found/exhausted=0, nonce and golden_nonce held; abort has priority over a simultaneous match.
REQ-031 abort in IDLE/FOUND/EXHAUSTED SHALL clear found/exhausted and go to IDLE; abort beats simultaneous start.
REQ-032 start in FOUND or EXHAUSTED (no abort) SHALL restart per REQ-020.
REQ-033 entry_12 and target SHALL remain stable from accepted start until the next accepted start.

Reset
REQ-034 reset low SHALL immediately force IDLE, all outputs 0, latency counter 0, regardless of state.
REQ-035 reset deasserted mid-search SHALL not resume; a new start is required.

Verification
REQ-036 Bench uses a behavioural hash model returning a programmed hash_in per nonce after HASH_LATENCY cycles; all scenarios use HASH_LATENCY=4.
REQ-037 Start, target=8'h10, hash 24'h0F0F00 on nonce 3 only -> selector pulses at cycles 1,7,13,19; found=1 at cycle 24; golden_nonce=3; busy=0.
REQ-038 NONCE_LIMIT=2, no matching hash -> exhausted=1 after 3 checks (cycle 18); nonce=2; found=0.
REQ-039 Boundary: hash 24'h101000 with target 8'h10 -> no match; hash 24'h0F1000 -> no match; 24'h0F0F00 -> match.
REQ-040 abort during WAIT of nonce 1 -> IDLE next cycle, busy=0, no further selector pulses; start at the same edge ignored.
REQ-041 reset pulsed low mid-WAIT -> all outputs 0 asynchronously; after release stays IDLE until start.
REQ-042 start while busy -> ignored, nonce sequence unchanged; start in FOUND -> fresh search from NONCE_START with new latched header.
